// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding and
// the width of the settle hold counter.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    // Wide enough for SETTLE_CYC in 0..15
    localparam int CNT_W = 4;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Host/function-under-test bundle for truth_table_sequencer. The sequencer
// takes the slave side; the host and the function block drive the master side.
interface truth_table_sequencer_if #(
    parameter int N_INPUTS = 3
);
    localparam int TW = 1 << N_INPUTS;

    logic                start;
    logic [TW-1:0]       expected;
    logic                s_in;
    logic [N_INPUTS-1:0] vec_out;
    logic                busy;
    logic                done;
    logic [TW-1:0]       table_out;
    logic                match;
    logic [N_INPUTS:0]   err_cnt;

    modport master (
        output start, expected, s_in,
        input  vec_out, busy, done, table_out, match, err_cnt
    );

    modport slave (
        input  start, expected, s_in,
        output vec_out, busy, done, table_out, match, err_cnt
    );

endinterface

// File: rtl/tt_hold_timer.sv
// Loadable down-counter that flags the final cycle of a settle window.
module tt_hold_timer
    import tt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a combinational function through all 2^N input codes and captures
// its truth table. Define TTSEQ_COMPARE_EN to add the expected-table check.
module truth_table_sequencer
    import tt_pkg::*;
#(
    parameter int N_INPUTS   = 3,
    parameter int SETTLE_CYC = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    truth_table_sequencer_if.slave bus
);

    localparam int TW = 1 << N_INPUTS;

    tt_state_t           state, state_nx;
    logic [N_INPUTS-1:0] vec_q;
    logic [TW-1:0]       tbl_q;
    logic                accept, last_code;
    logic                ld, dec, hold_last;

    assign accept    = (state == IDLE) && bus.start;
    assign last_code = &vec_q;

    tt_hold_timer u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .dec      (dec),
        .load_val (CNT_W'(SETTLE_CYC)),
        .last     (hold_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        dec      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    ld       = 1'b1;
                    state_nx = (SETTLE_CYC > 0) ? SETTLE : SAMPLE;
                end
            end
            SETTLE: begin
                dec = 1'b1;
                if (hold_last)
                    state_nx = SAMPLE;
            end
            SAMPLE: begin
                if (last_code)
                    state_nx = DONE;
                else if (SETTLE_CYC > 0) begin
                    ld       = 1'b1;
                    state_nx = SETTLE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q <= '0;
            tbl_q <= '0;
        end else if (accept) begin
            vec_q <= '0;
            tbl_q <= '0;
        end else if (state == SAMPLE) begin
            tbl_q[vec_q] <= bus.s_in;
            if (!last_code)
                vec_q <= vec_q + N_INPUTS'(1);
        end
    end

`ifdef TTSEQ_COMPARE_EN
    logic [TW-1:0]     exp_q;
    logic [N_INPUTS:0] err_q;
    logic              match_q, mis;

    assign mis = (bus.s_in != exp_q[vec_q]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q   <= '0;
            err_q   <= '0;
            match_q <= 1'b0;
        end else if (accept) begin
            exp_q   <= bus.expected;
            err_q   <= '0;
            match_q <= 1'b0;
        end else if (state == SAMPLE) begin
            err_q <= err_q + {{N_INPUTS{1'b0}}, mis};
            // Resolve match on the final sample so it is valid alongside done
            if (last_code)
                match_q <= (err_q == '0) && !mis;
        end
    end

    assign bus.err_cnt = err_q;
    assign bus.match   = match_q;
`else
    logic unused_expected;
    assign unused_expected = ^bus.expected;
    assign bus.err_cnt     = '0;
    assign bus.match       = 1'b0;
`endif

    assign bus.vec_out   = vec_q;
    assign bus.table_out = tbl_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench: table-driven sweeps, hand-written corner sequences and
// randomized function tables against a behavioural truth-table model.
module tb_truth_table_sequencer;

    localparam int N  = 3;
    localparam int TW = 1 << N;
    localparam int S0 = 1;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    logic          sel_rand;
    logic [TW-1:0] rtbl;

    truth_table_sequencer_if #(.N_INPUTS(N)) if0 ();
    truth_table_sequencer_if #(.N_INPUTS(N)) if1 ();

    truth_table_sequencer #(.N_INPUTS(N), .SETTLE_CYC(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    truth_table_sequencer #(.N_INPUTS(N), .SETTLE_CYC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    always #5 clk = ~clk;

    // Function under test: s = x & ~y & z
    function automatic logic fxyz(input logic [2:0] v);
        return v[2] & ~v[1] & v[0];
    endfunction

    assign if0.s_in = sel_rand ? rtbl[if0.vec_out] : fxyz(if0.vec_out);
    assign if1.s_in = sel_rand ? rtbl[if1.vec_out] : fxyz(if1.vec_out);

    function automatic logic [TW-1:0] model_tbl();
        logic [TW-1:0] t;
        for (int i = 0; i < TW; i++)
            t[i] = sel_rand ? rtbl[i] : fxyz(3'(i));
        return t;
    endfunction

    function automatic int model_err(input logic [TW-1:0] expv);
        int e = 0;
        logic [TW-1:0] t = model_tbl();
`ifdef TTSEQ_COMPARE_EN
        for (int i = 0; i < TW; i++)
            if (t[i] != expv[i]) e++;
`else
        e = 0 * int'(t[0] ^ expv[0]);
`endif
        return e;
    endfunction

    function automatic logic model_match(input logic [TW-1:0] expv);
`ifdef TTSEQ_COMPARE_EN
        return model_tbl() == expv;
`else
        return 1'b0 & (model_tbl() == expv);
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] outs0();
        return {16'd0, if0.vec_out, if0.busy, if0.done, if0.table_out, if0.match, if0.err_cnt};
    endfunction

    typedef struct {
        string         nm;
        logic [TW-1:0] expv;
        int            repulse;
        int            rst_at;
        int            chg;
        int            exp_lat;
        int            exp_nd;
    } row_t;

    // One sweep on dut0; inputs are driven right after a negedge
    task automatic sweep(input row_t r);
        int lat = -1;
        int nd  = 0;
        bit vec_ok = 1, busy_ok = 1;
        if0.expected = r.expv;
        if0.start    = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k < TW * (S0 + 1) && (r.rst_at < 0 || k <= r.rst_at) &&
                if0.vec_out !== 3'(k / (S0 + 1))) vec_ok = 0;
            if (if0.done === 1'b1) begin
                nd++;
                if (lat < 0) lat = k;
            end
            if (r.rst_at < 0 && k == 0  && if0.busy !== 1'b1) busy_ok = 0;
            if (r.rst_at < 0 && k == 16 && if0.busy !== 1'b1) busy_ok = 0;
            if (r.rst_at < 0 && k == 17 && if0.busy !== 1'b0) busy_ok = 0;
            if0.start = (k == r.repulse);
            if (k == r.chg) if0.expected = ~r.expv;
            if (k == r.rst_at) rst_n = 1'b0;
            if (r.rst_at >= 0 && k == r.rst_at + 1) begin
                check({r.nm, ".rst_outs"}, outs0(), 32'd0);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end
        check({r.nm, ".ndone"}, nd, r.exp_nd);
        check({r.nm, ".vec_step"}, vec_ok, 1);
        if (r.rst_at < 0) begin
            check({r.nm, ".lat"}, lat, r.exp_lat);
            check({r.nm, ".busy"}, busy_ok, 1);
            check({r.nm, ".table"}, if0.table_out, model_tbl());
            check({r.nm, ".match"}, if0.match, model_match(r.expv));
            check({r.nm, ".err"}, if0.err_cnt, model_err(r.expv));
            check({r.nm, ".vec_hold"}, if0.vec_out, TW - 1);
        end
    endtask

    task automatic sweep1(input string nm, input logic [TW-1:0] expv);
        int lat = -1;
        if1.expected = expv;
        if1.start    = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (if1.done === 1'b1 && lat < 0) lat = k;
            @(negedge clk);
        end
        check({nm, ".lat"}, lat, TW);
        check({nm, ".table"}, if1.table_out, model_tbl());
        check({nm, ".match"}, if1.match, model_match(expv));
        check({nm, ".err"}, if1.err_cnt, model_err(expv));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        row_t rows[5];
        rows[0] = '{"match20",  8'h20, -1, -1, -1, 16, 1};
        rows[1] = '{"exp00",    8'h00, -1, -1, -1, 16, 1};
        rows[2] = '{"repulse",  8'h20,  5, -1, -1, 16, 1};
        rows[3] = '{"midrst",   8'h20, -1,  9, -1, -1, 0};
        rows[4] = '{"expchg",   8'h20, -1, -1,  3, 16, 1};

        sel_rand = 1'b0; rtbl = '0;
        if0.start = 1'b0; if0.expected = '0;
        if1.start = 1'b0; if1.expected = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.dut0", outs0(), 32'd0);
        check("reset.dut1", {if1.vec_out, if1.busy, if1.done, if1.table_out, if1.match, if1.err_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) sweep(rows[i]);
        sweep(rows[0]);  // normal sweep right after the reset row

        // start held high: second sweep begins in the IDLE cycle after DONE
        begin
            int d1 = -1, d2 = -1;
            bit ok = 1;
            if0.expected = 8'h20;
            if0.start    = 1'b1;
            @(negedge clk);
            for (int k = 0; k <= 36; k++) begin
                if (if0.done === 1'b1) begin
                    if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
                end
                if (k == 17 && if0.busy !== 1'b0) ok = 0;
                if (k == 18 && if0.busy !== 1'b1) ok = 0;
                if (k == 34) if0.start = 1'b0;
                @(negedge clk);
            end
            check("cont.done1", d1, 16);
            check("cont.done2", d2, 34);
            check("cont.busy_gap", ok, 1);
            check("cont.idle", if0.busy, 0);
        end

        sweep1("s0.match20", 8'h20);
        sweep1("s0.exp00", 8'h00);

        sel_rand = 1'b1;
        for (int it = 0; it < 12; it++) begin
            row_t r;
            rtbl = TW'($urandom);
            r = '{"rand", TW'($urandom), -1, -1, -1, 16, 1};
            if (it % 4 == 0) r.expv = rtbl;
            sweep(r);
            sweep1("rand.s0", r.expv);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencer that exhaustively drives a small combinational function block (e.g. `fxyz`) through all 2^N input combinations in ascending binary order and captures each response into a truth-table vector. It replaces hand-written `#1` stimulus lists with a clocked, restartable sweep. It sits between a host or testbench, which issues `start` and an optional expected table, and the function-under-test, which receives `vec_out` and returns `s_in`. With the compare feature compiled in, it also checks the captured table against the expected one.

## Interface
- `N_INPUTS`, default 3: number of function inputs; table width is 2^N_INPUTS.
- `SETTLE_CYC`, default 1: extra hold cycles per combination before sampling, legal range 0..15.
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle request to begin a sweep.
- `expected` in 2^N: reference truth table, bit i = expected output for input i.
- `s_in` in 1: function output returned from the DUT.
- `vec_out` out N: input vector to the DUT; MSB = first input (x), LSB = last (z).
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse when the sweep completes.
- `table_out` out 2^N: captured truth table, bit i = sampled `s_in` while `vec_out == i`.
- `match` out 1: `table_out == expected` (compare build only).
- `err_cnt` out N+1: number of mismatching table bits (compare build only).

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `busy=0`.
  - On `start=1`: clear `table_out`, `err_cnt` and `match`; capture `expected` into an internal register; set `vec_out=0` and the hold counter to `SETTLE_CYC`.
  - If `SETTLE_CYC>0`, go to SETTLE; otherwise go to SAMPLE.
- SETTLE:
  - Decrement the hold counter each cycle; `vec_out` is held.
  - Go to SAMPLE when the counter reaches 1.
- SAMPLE:
  - Write `s_in` into `table_out[vec_out]`.
  - Compare build: if the sampled bit differs from the captured expected bit, increment `err_cnt`.
  - If `vec_out == 2^N-1`, go to DONE.
  - Otherwise increment `vec_out`, reload the counter, and go to SETTLE (or stay in SAMPLE when `SETTLE_CYC=0`).
- DONE:
  - Assert `done` for one cycle.
  - Update `match` from the final comparison.
  - Return to IDLE.
- `vec_out` holds its last value, 2^N-1, after a sweep until the next `start`.
- `table_out`, `match` and `err_cnt` hold until the next accepted `start`.
- `s_in` is sampled as-is; an X propagates into `table_out`.

## Timing
- Reset value of every output is 0: `vec_out`, `busy`, `done`, `table_out`, `match`, `err_cnt`.
- `busy` rises at the edge that accepts `start` and falls with the edge that leaves DONE.
- Each combination is held for `SETTLE_CYC+1` cycles. Sampling happens on the last edge of that window.
- Latency from the `start` edge to `done` high is 2^N·(SETTLE_CYC+1) cycles. With the defaults this is 16 cycles.
- Boundary conditions:
  - `start` while `busy`, including during DONE, is ignored.
  - `start` asserted continuously re-triggers a sweep from the IDLE cycle after DONE.
  - `expected` changes during a sweep have no effect, because the value is captured at `start`.
  - `rst_n=0` mid-sweep returns to IDLE on that edge with all outputs cleared. No `done` is produced.
- `err_cnt` saturation is impossible: its maximum is 2^N, which fits in N+1 bits.

## Configuration
- `TTSEQ_COMPARE_EN`
  - Defined: the expected-capture register, the per-sample comparator, `err_cnt` and `match` are present.
  - Undefined: `expected` is unused, `match` and `err_cnt` are tied to 0, and sweep timing is identical.

## Structure
- Shared package `tt_pkg`:
  - State encoding constants: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - The `SETTLE_CYC` counter width (4).
- One sub-module, `tt_hold_timer`: a loadable down-counter with a "last cycle" flag, used for the SETTLE window.
- The DUT (`fxyz`) is instantiated outside this block.

## Test plan
All scenarios use DUT `fxyz` (s = x·y'·z), N=3, SETTLE_CYC=1.
- Reset, then `start` with `expected=8'h20`:
  - `done` pulses 16 cycles after the `start` edge.
  - `table_out=8'h20`, `match=1`, `err_cnt=0`.
  - `vec_out` steps 0..7, each value held 2 cycles.
- `expected=8'h00`: `table_out=8'h20`, `match=0`, `err_cnt=1`.
- `start` re-pulsed at cycle 5 of a sweep:
  - The re-pulse is ignored.
  - `done` still pulses exactly once, 16 cycles after the first `start`.
- `rst_n=0` at cycle 9 of a sweep:
  - All outputs are 0 on the next cycle and no `done` is produced.
  - A following `start` completes normally with `table_out=8'h20`.
- SETTLE_CYC=0:
  - `done` pulses 8 cycles after `start`.
  - `table_out=8'h20`.
- Build without `TTSEQ_COMPARE_EN`, `expected=8'h00`:
  - `table_out=8'h20`.
  - `match=0` and `err_cnt=0` throughout.
